// File: rtl/plot_arbiter_pkg.sv
// Shared definitions for the VGA plot-port arbiter: screen geometry, default
// field widths, FSM encoding and the round-robin pointer helper.
package plot_arbiter_pkg;

   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;
   localparam int PLOT_X_W = 8;
   localparam int PLOT_Y_W = 7;
   localparam int PLOT_C_W = 3;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_BURST   = 2'd1,
      S_RELEASE = 2'd2
   } arb_state_t;

   // Lane after `lane`, wrapping at n_req.
   function automatic logic [1:0] next_lane(input logic [1:0] lane, input int n_req);
      logic [1:0] nxt_s;
      if (int'(lane) >= n_req - 1) begin
         nxt_s = 2'd0;
      end else begin
         nxt_s = lane + 2'd1;
      end
      return nxt_s;
   endfunction

endpackage

// File: rtl/plot_arbiter_rr_pick.sv
// Combinational round-robin search: first requesting lane at or after rr_ptr,
// wrapping modulo N_REQ.
module rr_pick #(
   parameter int N_REQ = 3
) (
   input  logic [N_REQ-1:0] req,
   input  logic [1:0]       rr_ptr,
   output logic             found,
   output logic [1:0]       idx
);

   localparam int IDX_W = $clog2(N_REQ);

   // Walk from the farthest candidate back to rr_ptr so the nearest requester wins.
   always_comb begin
      int cand_s;
      found  = 1'b0;
      idx    = 2'd0;
      cand_s = 0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         cand_s = int'(rr_ptr) + k;
         if (cand_s >= N_REQ) begin
            cand_s = cand_s - N_REQ;
         end else begin
            cand_s = cand_s + 0;
         end
         found = found | req[IDX_W'(cand_s)];
         idx   = req[IDX_W'(cand_s)] ? 2'(cand_s) : idx;
      end
   end

endmodule

// File: rtl/plot_arbiter.sv
// Shares the single vga_adapter plot port among N_REQ drawing engines with
// round-robin bursts capped at MAX_BURST pixels per grant.
module plot_arbiter
   import plot_arbiter_pkg::*;
#(
   parameter int N_REQ     = 3,
   parameter int X_W       = PLOT_X_W,
   parameter int Y_W       = PLOT_Y_W,
   parameter int C_W       = PLOT_C_W,
   parameter int MAX_BURST = 64
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [N_REQ-1:0]   req,
   input  logic [N_REQ-1:0]   last,
   input  logic [N_REQ*X_W-1:0] x_in,
   input  logic [N_REQ*Y_W-1:0] y_in,
   input  logic [N_REQ*C_W-1:0] colour_in,
   output logic [N_REQ-1:0]   grant,
   output logic               writeEn,
   output logic [X_W-1:0]     x,
   output logic [Y_W-1:0]     y,
   output logic [C_W-1:0]     colour,
   output logic               busy,
   output logic [1:0]         owner
);

   localparam int CNT_W = $clog2(MAX_BURST) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);
   localparam logic [CNT_W-1:0] CNT_SAT  = '1;

   arb_state_t        state_r, state_s;
   logic [1:0]        rr_ptr_r, rr_ptr_s;
   logic [CNT_W-1:0]  beat_cnt_r, beat_cnt_s;
   logic [N_REQ-1:0]  grant_r, grant_s;
   logic [1:0]        owner_r, owner_s;
   logic              busy_r, busy_s;
   logic              we_r, we_s;
   logic [X_W-1:0]    x_r, x_s;
   logic [Y_W-1:0]    y_r, y_s;
   logic [C_W-1:0]    c_r, c_s;
   logic              found_s;
   logic [1:0]        pick_idx_s;
   logic              accept_s;
   logic [X_W-1:0]    x_lane_s [N_REQ];
   logic [Y_W-1:0]    y_lane_s [N_REQ];
   logic [C_W-1:0]    c_lane_s [N_REQ];

   for (genvar g = 0; g < N_REQ; g++) begin : g_lane
      assign x_lane_s[g] = x_in[g*X_W +: X_W];
      assign y_lane_s[g] = y_in[g*Y_W +: Y_W];
      assign c_lane_s[g] = colour_in[g*C_W +: C_W];
   end

   rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
      .req    (req),
      .rr_ptr (rr_ptr_r),
      .found  (found_s),
      .idx    (pick_idx_s)
   );

   assign accept_s = req[owner_r] & grant_r[owner_r];

   // Next-state, grant and plot-register values; data regs hold unless a pixel is accepted.
   always_comb begin
      state_s    = state_r;
      rr_ptr_s   = rr_ptr_r;
      beat_cnt_s = beat_cnt_r;
      grant_s    = grant_r;
      owner_s    = owner_r;
      busy_s     = busy_r;
      we_s       = 1'b0;
      x_s        = x_r;
      y_s        = y_r;
      c_s        = c_r;
      case (state_r)
         S_IDLE: begin
            if (found_s) begin
               grant_s             = '0;
               grant_s[pick_idx_s] = 1'b1;
               owner_s             = pick_idx_s;
               busy_s              = 1'b1;
               beat_cnt_s          = '0;
               state_s             = S_BURST;
            end else begin
               grant_s = '0;
               busy_s  = 1'b0;
            end
         end
         S_BURST: begin
            if (accept_s) begin
               we_s       = 1'b1;
               x_s        = x_lane_s[owner_r];
               y_s        = y_lane_s[owner_r];
               c_s        = c_lane_s[owner_r];
               beat_cnt_s = (beat_cnt_r == CNT_SAT) ? beat_cnt_r : beat_cnt_r + CNT_W'(1);
            end else begin
               we_s = 1'b0;
            end
            // Leave on last pixel, on a dropped req, or on the MAX_BURST-th accept.
            if (!accept_s || last[owner_r] || (beat_cnt_r == CNT_LAST)) begin
               state_s  = S_RELEASE;
               grant_s  = '0;
               busy_s   = 1'b0;
               rr_ptr_s = next_lane(owner_r, N_REQ);
            end else begin
               state_s = S_BURST;
            end
         end
         S_RELEASE: begin
            state_s = S_IDLE;
            grant_s = '0;
            busy_s  = 1'b0;
         end
         default: begin
            state_s = S_IDLE;
            grant_s = '0;
            busy_s  = 1'b0;
         end
      endcase
   end

   // State and registered plot-port outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r    <= S_IDLE;
         rr_ptr_r   <= 2'd0;
         beat_cnt_r <= '0;
         grant_r    <= '0;
         owner_r    <= 2'd0;
         busy_r     <= 1'b0;
         we_r       <= 1'b0;
         x_r        <= '0;
         y_r        <= '0;
         c_r        <= '0;
      end else begin
         state_r    <= state_s;
         rr_ptr_r   <= rr_ptr_s;
         beat_cnt_r <= beat_cnt_s;
         grant_r    <= grant_s;
         owner_r    <= owner_s;
         busy_r     <= busy_s;
         we_r       <= we_s;
         x_r        <= x_s;
         y_r        <= y_s;
         c_r        <= c_s;
      end
   end

   assign grant   = grant_r;
   assign writeEn = we_r;
   assign x       = x_r;
   assign y       = y_r;
   assign colour  = c_r;
   assign busy    = busy_r;
   assign owner   = owner_r;

endmodule

// File: tb/tb_plot_arbiter.sv
// Directed bench for plot_arbiter: cycle vectors plus reactive requester
// sequences for round-robin order, burst cap and mid-burst reset.
module tb_plot_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [2:0]  req, last;
   logic [23:0] x_in;
   logic [20:0] y_in;
   logic [8:0]  colour_in;
   logic [2:0]  grant;
   logic        writeEn;
   logic [7:0]  x;
   logic [6:0]  y;
   logic [2:0]  colour;
   logic        busy;
   logic [1:0]  owner;

   int n_cmp = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   plot_arbiter dut (
      .clk(clk), .reset_n(reset_n), .req(req), .last(last),
      .x_in(x_in), .y_in(y_in), .colour_in(colour_in),
      .grant(grant), .writeEn(writeEn), .x(x), .y(y), .colour(colour),
      .busy(busy), .owner(owner)
   );

   typedef struct {
      logic [2:0]  req;
      logic [2:0]  last;
      logic [23:0] xi;
      logic [20:0] yi;
      logic [8:0]  ci;
      logic [2:0]  g;
      logic        we;
      logic [7:0]  x;
      logic [6:0]  y;
      logic [2:0]  c;
      logic        b;
      logic [1:0]  o;
   } vec_t;

   vec_t vecs[20];

   logic [2:0] grant_log[$];
   int         burst_log[$];
   int         gap_log[$];
   int         first_log[$];
   int         cnt_a[3];
   int         pos_a[3];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [23:0] xl(input int lane, input int v);
      logic [23:0] r = '0;
      r[lane*8 +: 8] = 8'(v);
      return r;
   endfunction

   function automatic logic [20:0] yl(input int lane, input int v);
      logic [20:0] r = '0;
      r[lane*7 +: 7] = 7'(v);
      return r;
   endfunction

   function automatic logic [8:0] cl(input int lane, input int v);
      logic [8:0] r = '0;
      r[lane*3 +: 3] = 3'(v);
      return r;
   endfunction

   function automatic vec_t mk(input logic [2:0] rq, input logic [2:0] ls, input logic [23:0] xi,
                               input logic [20:0] yi, input logic [8:0] ci, input logic [2:0] g,
                               input logic we, input int ex, input int ey, input int ec,
                               input logic b, input int o);
      vec_t v;
      v.req = rq; v.last = ls; v.xi = xi; v.yi = yi; v.ci = ci;
      v.g = g; v.we = we; v.x = 8'(ex); v.y = 7'(ey); v.c = 3'(ec); v.b = b; v.o = 2'(o);
      return v;
   endfunction

   task automatic do_reset();
      reset_n = 1'b0; req = 3'b000; last = 3'b000;
      x_in = '0; y_in = '0; colour_in = '0;
      tick();
      reset_n = 1'b1;
   endtask

   task automatic drive_lanes(input int blen);
      for (int i = 0; i < 3; i++) begin
         if (pos_a[i] < cnt_a[i]) begin
            req[i] = 1'b1;
            x_in[i*8 +: 8] = 8'(pos_a[i]);
            y_in[i*7 +: 7] = 7'(i + 1);
            colour_in[i*3 +: 3] = 3'(pos_a[i]);
            last[i] = (pos_a[i] == cnt_a[i] - 1) || (blen > 0 && (pos_a[i] % blen) == blen - 1);
         end else begin
            req[i] = 1'b0;
            last[i] = 1'b0;
         end
      end
   endtask

   // Requesters advance on accept (req & grant at the edge); logs grant order, burst sizes, gaps.
   task automatic run_lanes(input int c0, input int c1, input int c2, input int blen, input int budget);
      logic [2:0] gprev, acc;
      int cur_burst, gap, cyc;
      bit done;
      cnt_a = '{c0, c1, c2};
      pos_a = '{0, 0, 0};
      grant_log.delete(); burst_log.delete(); gap_log.delete(); first_log.delete();
      gprev = 3'b000; cur_burst = 0; gap = 0; cyc = 0; done = 1'b0;
      drive_lanes(blen);
      while (!done && cyc < budget) begin
         tick();
         cyc++;
         acc = req & gprev;
         chk("run writeEn", {31'd0, writeEn}, {31'd0, |acc});
         for (int i = 0; i < 3; i++) begin
            if (acc[i]) begin
               chk($sformatf("run x lane%0d", i), {24'd0, x}, 32'(pos_a[i] % 256));
               chk($sformatf("run y lane%0d", i), {25'd0, y}, 32'(i + 1));
               chk($sformatf("run colour lane%0d", i), {29'd0, colour}, 32'(pos_a[i] % 8));
               if (cur_burst == 0) first_log.push_back(pos_a[i]);
               cur_burst++;
               pos_a[i]++;
            end
         end
         if (grant != gprev) begin
            if (gprev != 3'b000) begin
               burst_log.push_back(cur_burst);
               cur_burst = 0;
            end
            if (grant != 3'b000) begin
               grant_log.push_back(grant);
               if (grant_log.size() > 1) gap_log.push_back(gap);
            end
         end
         gap = (grant == 3'b000) ? gap + 1 : 0;
         gprev = grant;
         drive_lanes(blen);
         done = (pos_a[0] == cnt_a[0]) && (pos_a[1] == cnt_a[1]) && (pos_a[2] == cnt_a[2])
                && (grant == 3'b000);
      end
      chk("run completed within budget", {31'd0, done}, 32'd1);
   endtask

   task automatic chk_logs(input string tag, input logic [2:0] eg[$], input int eb[$],
                           input int ef[$], input int egap[$]);
      chk({tag, " grant count"}, 32'(grant_log.size()), 32'(eg.size()));
      chk({tag, " burst count"}, 32'(burst_log.size()), 32'(eb.size()));
      chk({tag, " gap count"}, 32'(gap_log.size()), 32'(egap.size()));
      for (int i = 0; i < eg.size() && i < grant_log.size(); i++)
         chk($sformatf("%s grant[%0d]", tag, i), {29'd0, grant_log[i]}, {29'd0, eg[i]});
      for (int i = 0; i < eb.size() && i < burst_log.size(); i++)
         chk($sformatf("%s burst[%0d]", tag, i), 32'(burst_log[i]), 32'(eb[i]));
      for (int i = 0; i < ef.size() && i < first_log.size(); i++)
         chk($sformatf("%s first pixel[%0d]", tag, i), 32'(first_log[i]), 32'(ef[i]));
      for (int i = 0; i < egap.size() && i < gap_log.size(); i++)
         chk($sformatf("%s gap[%0d]", tag, i), 32'(gap_log[i]), 32'(egap[i]));
   endtask

   initial begin
      // Reset held with all lanes requesting: nothing may be granted or plotted.
      reset_n = 1'b0; req = 3'b111; last = 3'b000;
      x_in = {8'd3, 8'd2, 8'd1}; y_in = {7'd3, 7'd2, 7'd1}; colour_in = {3'd3, 3'd2, 3'd1};
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("reset grant", {29'd0, grant}, 32'd0);
         chk("reset writeEn", {31'd0, writeEn}, 32'd0);
         chk("reset xyc", {12'd0, x, y, colour}, 32'd0);
         chk("reset busy/owner", {29'd0, busy, owner}, 32'd0);
      end
      reset_n = 1'b1;
      chk("post-reset grant before edge", {29'd0, grant}, 32'd0);
      tick();
      chk("first grant after reset", {29'd0, grant}, 32'd1);
      chk("first owner after reset", {30'd0, owner}, 32'd0);
      do_reset();

      // Single burst on lane1, drop-req burst on lane2, then rr_ptr wrap to lane0.
      vecs[0]  = mk(3'b010, 3'b000, xl(1,10), yl(1,35), cl(1,5), 3'b010, 1'b0,  0,  0, 0, 1'b1, 1);
      vecs[1]  = mk(3'b010, 3'b000, xl(1,10), yl(1,35), cl(1,5), 3'b010, 1'b1, 10, 35, 5, 1'b1, 1);
      vecs[2]  = mk(3'b010, 3'b000, xl(1,11), yl(1,35), cl(1,5), 3'b010, 1'b1, 11, 35, 5, 1'b1, 1);
      vecs[3]  = mk(3'b010, 3'b000, xl(1,12), yl(1,35), cl(1,5), 3'b010, 1'b1, 12, 35, 5, 1'b1, 1);
      vecs[4]  = mk(3'b010, 3'b000, xl(1,13), yl(1,35), cl(1,5), 3'b010, 1'b1, 13, 35, 5, 1'b1, 1);
      vecs[5]  = mk(3'b010, 3'b010, xl(1,14), yl(1,35), cl(1,5), 3'b000, 1'b1, 14, 35, 5, 1'b0, 1);
      vecs[6]  = mk(3'b000, 3'b000, xl(1,14), yl(1,35), cl(1,5), 3'b000, 1'b0, 14, 35, 5, 1'b0, 1);
      vecs[7]  = mk(3'b000, 3'b000, xl(1,14), yl(1,35), cl(1,5), 3'b000, 1'b0, 14, 35, 5, 1'b0, 1);
      vecs[8]  = mk(3'b100, 3'b000, xl(2,50), yl(2,60), cl(2,3), 3'b100, 1'b0, 14, 35, 5, 1'b1, 2);
      vecs[9]  = mk(3'b100, 3'b000, xl(2,50), yl(2,60), cl(2,3), 3'b100, 1'b1, 50, 60, 3, 1'b1, 2);
      vecs[10] = mk(3'b100, 3'b000, xl(2,51), yl(2,60), cl(2,3), 3'b100, 1'b1, 51, 60, 3, 1'b1, 2);
      vecs[11] = mk(3'b100, 3'b000, xl(2,52), yl(2,60), cl(2,3), 3'b100, 1'b1, 52, 60, 3, 1'b1, 2);
      vecs[12] = mk(3'b000, 3'b000, xl(2,52), yl(2,60), cl(2,3), 3'b000, 1'b0, 52, 60, 3, 1'b0, 2);
      vecs[13] = mk(3'b011, 3'b000, xl(1,80) | xl(0,70), yl(1,6) | yl(0,5), cl(1,2) | cl(0,1),
                    3'b000, 1'b0, 52, 60, 3, 1'b0, 2);
      vecs[14] = mk(3'b011, 3'b000, xl(1,80) | xl(0,70), yl(1,6) | yl(0,5), cl(1,2) | cl(0,1),
                    3'b001, 1'b0, 52, 60, 3, 1'b1, 0);
      vecs[15] = mk(3'b011, 3'b001, xl(1,80) | xl(0,70), yl(1,6) | yl(0,5), cl(1,2) | cl(0,1),
                    3'b000, 1'b1, 70, 5, 1, 1'b0, 0);
      vecs[16] = mk(3'b010, 3'b000, xl(1,80), yl(1,6), cl(1,2), 3'b000, 1'b0, 70, 5, 1, 1'b0, 0);
      vecs[17] = mk(3'b010, 3'b000, xl(1,80), yl(1,6), cl(1,2), 3'b010, 1'b0, 70, 5, 1, 1'b1, 1);
      vecs[18] = mk(3'b010, 3'b010, xl(1,80), yl(1,6), cl(1,2), 3'b000, 1'b1, 80, 6, 2, 1'b0, 1);
      vecs[19] = mk(3'b000, 3'b000, xl(1,80), yl(1,6), cl(1,2), 3'b000, 1'b0, 80, 6, 2, 1'b0, 1);

      for (int v = 0; v < 20; v++) begin
         req = vecs[v].req; last = vecs[v].last;
         x_in = vecs[v].xi; y_in = vecs[v].yi; colour_in = vecs[v].ci;
         tick();
         chk($sformatf("vec%0d grant", v), {29'd0, grant}, {29'd0, vecs[v].g});
         chk($sformatf("vec%0d writeEn", v), {31'd0, writeEn}, {31'd0, vecs[v].we});
         chk($sformatf("vec%0d x", v), {24'd0, x}, {24'd0, vecs[v].x});
         chk($sformatf("vec%0d y", v), {25'd0, y}, {25'd0, vecs[v].y});
         chk($sformatf("vec%0d colour", v), {29'd0, colour}, {29'd0, vecs[v].c});
         chk($sformatf("vec%0d busy", v), {31'd0, busy}, {31'd0, vecs[v].b});
         chk($sformatf("vec%0d owner", v), {30'd0, owner}, {30'd0, vecs[v].o});
      end

      // Mid-burst reset on lane2 (rr_ptr is 2 here); restart must search from lane0.
      req = 3'b100; last = 3'b000;
      x_in = xl(2,90); y_in = yl(2,60); colour_in = cl(2,3);
      tick();
      chk("mrst grant lane2", {29'd0, grant}, 32'd4);
      tick();
      chk("mrst plot before reset", {31'd0, writeEn}, 32'd1);
      chk("mrst x before reset", {24'd0, x}, 32'd90);
      x_in = xl(2,91);
      #3;
      reset_n = 1'b0;
      #1;
      chk("mrst grant falls", {29'd0, grant}, 32'd0);
      chk("mrst writeEn falls", {31'd0, writeEn}, 32'd0);
      chk("mrst busy/x cleared", {23'd0, busy, x}, 32'd0);
      req = 3'b111;
      x_in = {8'd7, 8'd6, 8'd5};
      tick();
      chk("mrst no plot in reset", {31'd0, writeEn}, 32'd0);
      reset_n = 1'b1;
      tick();
      chk("mrst restart grant", {29'd0, grant}, 32'd1);
      chk("mrst restart no plot", {31'd0, writeEn}, 32'd0);

      // Round robin with all lanes holding 2-pixel bursts.
      do_reset();
      run_lanes(4, 2, 2, 2, 200);
      chk_logs("rr", '{3'b001, 3'b010, 3'b100, 3'b001}, '{2, 2, 2, 2}, '{0, 0, 0, 2}, '{2, 2, 2});

      // Burst cap: lane0 streams 100 pixels while lane2 waits with 3.
      do_reset();
      run_lanes(100, 0, 3, 0, 400);
      chk_logs("cap", '{3'b001, 3'b100, 3'b001}, '{64, 3, 36}, '{0, 0, 64}, '{2, 2});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
